// File: rtl/game_op_sequencer.sv
// Control FSM for one play of the 24 game: holds four slot values, collects
// operand/operator key selections and sequences a shared multi-cycle ALU.
module game_op_sequencer #(
   parameter int W       = 10,
   parameter int TARGET  = 24,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] n1,
   input  logic [W-1:0] n2,
   input  logic [W-1:0] n3,
   input  logic [W-1:0] n4,
   input  logic         restart,
   input  logic         key_valid,
   input  logic [3:0]   key,
   output logic         alu_start,
   output logic [1:0]   alu_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic         alu_done,
   input  logic [W-1:0] alu_result,
   input  logic         alu_err,
   output logic [W-1:0] v1,
   output logic [W-1:0] v2,
   output logic [W-1:0] v3,
   output logic [W-1:0] v4,
   output logic [3:0]   live,
   output logic [2:0]   remaining,
   output logic         busy,
   output logic         err,
   output logic         win
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PICK_A, S_PICK_B, S_PICK_OP, S_ISSUE, S_WAIT, S_WRITE, S_DONE
   } state_t;

   state_t         state, nstate;
   logic [W-1:0]   vals  [4];
   logic [W-1:0]   saved [4];
   logic [1:0]     sa, sb;
   logic [W-1:0]   res;
   logic [CW-1:0]  cnt;
   logic           key_slot, key_op, key_cancel, sub_bad, div_bad, restart_ok;
   logic [1:0]     kidx;
   logic [W-1:0]   final_val;

   function automatic logic [2:0] popcount(input logic [3:0] x);
      return 3'(x[0]) + 3'(x[1]) + 3'(x[2]) + 3'(x[3]);
   endfunction

   // Key A/B/C/D map to add/sub/div/mul; ALU encodes mul as 10 and div as 11.
   function automatic logic [1:0] op_code(input logic [3:0] k);
      case (k)
         4'hA:    return 2'b00;
         4'hB:    return 2'b01;
         4'hC:    return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   assign kidx       = 2'(key - 4'd1);
   assign key_slot   = key_valid && (key >= 4'd1) && (key <= 4'd4);
   assign key_op     = key_valid && (key >= 4'hA) && (key <= 4'hD);
   assign key_cancel = key_valid && (key == 4'hE);
   assign sub_bad    = (alu_op == 2'b01) && (alu_b > alu_a);
   assign div_bad    = (alu_op == 2'b11) && (alu_b == '0);
   assign restart_ok = restart && (state != S_IDLE);

   assign v1        = vals[0];
   assign v2        = vals[1];
   assign v3        = vals[2];
   assign v4        = vals[3];
   assign remaining = popcount(live);
   assign busy      = (state == S_ISSUE) || (state == S_WAIT);

   always_comb begin
      final_val = '0;
      for (int i = 0; i < 4; i++)
         if (live[i]) final_val = vals[i];
   end

   assign win = (state == S_DONE) && (final_val == W'(TARGET));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate    = state;
      alu_start = 1'b0;
      err       = 1'b0;
      if (load || restart_ok) begin
         nstate = S_PICK_A;
      end else begin
         case (state)
            S_PICK_A:
               if (key_slot && live[kidx]) nstate = S_PICK_B;
            S_PICK_B:
               if (key_slot && live[kidx] && (kidx != sa)) nstate = S_PICK_OP;
               else if (key_cancel)                        nstate = S_PICK_A;
            S_PICK_OP:
               if (key_op)          nstate = S_ISSUE;
               else if (key_cancel) nstate = S_PICK_A;
            S_ISSUE:
               if (sub_bad || div_bad) begin
                  err    = 1'b1;
                  nstate = S_PICK_A;
               end else begin
                  alu_start = 1'b1;
                  nstate    = S_WAIT;
               end
            S_WAIT:
               if (alu_done) begin
                  err    = alu_err;
                  nstate = alu_err ? S_PICK_A : S_WRITE;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  err    = 1'b1;
                  nstate = S_PICK_A;
               end
            S_WRITE:
               nstate = (popcount(live & ~(4'b0001 << sb)) == 3'd1) ? S_DONE : S_PICK_A;
            default: nstate = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            vals[i]  <= '0;
            saved[i] <= '0;
         end
         live   <= '0;
         sa     <= '0;
         sb     <= '0;
         alu_op <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
         res    <= '0;
         cnt    <= '0;
      end else if (load) begin
         vals[0] <= n1;  vals[1] <= n2;  vals[2] <= n3;  vals[3] <= n4;
         saved[0] <= n1; saved[1] <= n2; saved[2] <= n3; saved[3] <= n4;
         live <= 4'b1111;
         sa   <= '0;
         sb   <= '0;
      end else if (restart_ok) begin
         for (int i = 0; i < 4; i++) vals[i] <= saved[i];
         live <= 4'b1111;
         sa   <= '0;
         sb   <= '0;
      end else begin
         case (state)
            S_PICK_A:
               if (key_slot && live[kidx]) sa <= kidx;
            S_PICK_B:
               if (key_slot && live[kidx] && (kidx != sa)) sb <= kidx;
            S_PICK_OP:
               // Operands are frozen here so they stay stable through WAIT.
               if (key_op) begin
                  alu_op <= op_code(key);
                  alu_a  <= vals[sa];
                  alu_b  <= vals[sb];
               end
            S_ISSUE:
               cnt <= '0;
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               if (alu_done && !alu_err) res <= alu_result;
            end
            S_WRITE: begin
               vals[sa] <= res;
               live[sb] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/game_op_sequencer.md
Name: game_op_sequencer

Overview:
- Control FSM for one play of the 24 game; sits between the keypad decoder / puzzle generator and a shared multi-cycle arithmetic unit.
- Holds the four working slot values, takes operand/operator selections from decoded keys, and issues one operation at a time to the ALU over a start/done handshake.
- Writes each ALU result back into a slot and reports remaining count and win.
- The ALU stays a pure datapath; this block sequences it.

Parameters:
- W, 10, slot / operand width (unsigned)
- TARGET, 24, winning final value
- TIMEOUT, 64, max cycles to wait for alu_done before aborting

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- load  in  1  pulse: capture n1..n4 as a new puzzle
- n1,n2,n3,n4  in  W each  puzzle numbers from the generator
- restart  in  1  pulse: restore the puzzle captured at last load
- key_valid  in  1  one-cycle strobe, key is valid
- key  in  4  decoded key: 1–4 = slot, A = add, B = sub, C = div, D = mul, E = cancel
- alu_start  out  1  one-cycle issue pulse
- alu_op  out  2  00 add, 01 sub, 10 mul, 11 div
- alu_a, alu_b  out  W each  operands, held stable from alu_start until alu_done
- alu_done  in  1  result valid strobe
- alu_result  in  W  ALU result
- alu_err  in  1  qualified by alu_done: non-exact division or overflow
- v1,v2,v3,v4  out  W each  current slot values
- live  out  4  bit i = slot i+1 still in play
- remaining  out  3  popcount(live)
- busy  out  1  high in ISSUE/WAIT
- err  out  1  one-cycle pulse on rejected or failed operation
- win  out  1  high in DONE when the surviving slot equals TARGET

Behaviour:
- Reset: state IDLE; v1–v4 = 0; saved copy = 0; live = 0; alu_start, busy, err, win = 0; alu_op, alu_a, alu_b = 0.
- Priority each cycle: rst > load > restart > key/ALU handling.
- load (any state, including WAIT): v = n, saved = n, live = 1111, go to PICK_A. A later alu_done is ignored.
- restart (any state except IDLE): v = saved, live = 1111, selections cleared, go to PICK_A. A pending ALU result is discarded. restart in IDLE is ignored.
- Keys are acted on only when key_valid = 1; any key not listed for the current state is ignored without err.
- PICK_A:
  - Slot key with live bit set: latch slot index sa, go to PICK_B.
  - Slot key for a dead slot: ignored.
- PICK_B:
  - Slot key, live and different from sa: latch sb, go to PICK_OP.
  - Key equal to sa: ignored.
  - E: back to PICK_A.
- PICK_OP:
  - A/B/C/D: latch op, go to ISSUE.
  - E: back to PICK_A.
- ISSUE (1 cycle):
  - Pre-checks: sub with v[sb] > v[sa], or div with v[sb] == 0, pulses err and returns to PICK_A with no ALU activity.
  - Otherwise drive alu_a = v[sa], alu_b = v[sb], alu_op, alu_start = 1 for exactly this cycle; go to WAIT and clear the timeout counter.
- WAIT: busy = 1; counter increments each cycle.
  - alu_done with alu_err = 0: go to WRITE and register the result.
  - alu_done with alu_err = 1: err pulse, go to PICK_A; slots unchanged.
  - Counter reaches TIMEOUT before done: err pulse, go to PICK_A.
  - alu_done outside WAIT: ignored.
- WRITE (1 cycle): v[sa] = result, live[sb] = 0.
  - If remaining becomes 1: go to DONE.
  - Else: go to PICK_A.
- Result latency: visible on v one cycle after alu_done (the WRITE cycle commits; outputs update on the following edge).
- DONE: win = (value of the single live slot == TARGET), held until load, restart or rst; all keys ignored.
- Cleared slots keep their last value on v but are excluded by live.
- err is never asserted together with a slot write.

Test Plan:
- rst, then load (3,8,1,1) -> live = 1111, remaining = 4, PICK_A. Keys 2, 1, D -> alu_start one cycle with a = 8, b = 3, op = 10. alu_done with result 24 -> next cycle v2 = 24, live = 1110, remaining = 3.
- Continue with keys 2,3,D (result 24), then 2,4,D (result 24) -> live = 0010, remaining = 1, DONE, win = 1. Further keys change nothing.
- Keys 1, 2, B with v1 = 3, v2 = 8 -> err pulse, no alu_start, PICK_A, slots unchanged. Key 1 then key 1 again -> second press ignored, still PICK_B. Key E in PICK_OP -> PICK_A.
- Divide issued, alu_done with alu_err = 1 -> err pulse, slots unchanged. Divide issued, no alu_done for 64 cycles -> err at timeout, busy drops. A late alu_done then has no effect.
- restart asserted during WAIT after one committed op -> v = saved (3,8,1,1), live = 1111. alu_done arriving the next cycle ignored.
- load and restart asserted in the same cycle -> load values captured. rst during WAIT -> all outputs return to reset values next cycle.
